// File: rtl/spi_wb_bridge_fsm_pkg.sv
// spi_wb_bridge_fsm_pkg: shared state encoding, command bit position and error bit indices
package spi_wb_bridge_fsm_pkg;
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_WAIT,
    WR_EXE,
    RD_EXE,
    RD_LOAD,
    RD_WAIT,
    ABORT
  } state_t;
  localparam int CMD_BIT = 7;
  localparam int ERR_TMO = 0;
  localparam int ERR_OVR = 1;
endpackage

// File: rtl/spi_wb_bridge_fsm_if.sv
// spi_wb_bridge_fsm_if: SPI byte-stream and Wishbone classic signals seen by the bridge
interface spi_wb_bridge_fsm_if #(
  parameter int ADDR_W = 7
);
  logic              spi_rdy;
  logic [7:0]        spi_rx;
  logic              spi_cs_n;
  logic              spi_ld;
  logic [7:0]        spi_tx;
  logic [ADDR_W-1:0] wb_adr;
  logic [7:0]        wb_wdat;
  logic [7:0]        wb_rdat;
  logic              wb_we;
  logic              wb_stb;
  logic              wb_cyc;
  logic              wb_ack;
  logic              busy;
  logic [1:0]        err;
  modport master (
    input  spi_rdy, spi_rx, spi_cs_n, wb_rdat, wb_ack,
    output spi_ld, spi_tx, wb_adr, wb_wdat, wb_we, wb_stb, wb_cyc, busy, err
  );
  modport slave (
    output spi_rdy, spi_rx, spi_cs_n, wb_rdat, wb_ack,
    input  spi_ld, spi_tx, wb_adr, wb_wdat, wb_we, wb_stb, wb_cyc, busy, err
  );
endinterface

// File: rtl/spi_wb_timeout_cnt.sv
// spi_wb_timeout_cnt: counts unacknowledged strobe cycles, flags the last allowed one
module spi_wb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [15:0] cnt;
  assign tc = en && cnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/spi_wb_bridge_fsm.sv
// spi_wb_bridge_fsm: SPI command/byte stream to Wishbone burst master with write buffer and ack timeout
module spi_wb_bridge_fsm
  import spi_wb_bridge_fsm_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int AUTO_INC    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input logic clk,
  input logic reset,
  spi_wb_bridge_fsm_if.master bus
);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(AUTO_INC);
  state_t     state;
  logic       cmd;
  logic       buf_full;
  logic [7:0] buf_q;
  logic       ok;
  logic       tc;
  assign ok       = bus.wb_stb && bus.wb_ack;
  assign bus.busy = state != IDLE;
  spi_wb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .reset (reset),
    .clr   (!bus.wb_stb),
    .en    (bus.wb_stb && !bus.wb_ack),
    .tc    (tc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd         <= 1'b0;
      buf_full    <= 1'b0;
      buf_q       <= '0;
      bus.spi_ld  <= 1'b0;
      bus.spi_tx  <= '0;
      bus.wb_adr  <= '0;
      bus.wb_wdat <= '0;
      bus.wb_we   <= 1'b0;
      bus.wb_stb  <= 1'b0;
      bus.wb_cyc  <= 1'b0;
      bus.err     <= '0;
    end else begin
      bus.spi_ld <= 1'b0;
      bus.err    <= '0;
      if (tc) begin
        {bus.wb_cyc, bus.wb_stb, bus.wb_we} <= '0;
        bus.err[ERR_TMO] <= 1'b1;
        buf_full         <= 1'b0;
        state            <= ABORT;
      end else begin
        case (state)
          IDLE: if (bus.spi_rdy && !bus.spi_cs_n) begin
            cmd        <= bus.spi_rx[CMD_BIT];
            bus.wb_adr <= bus.spi_rx[ADDR_W-1:0];
            state      <= CMD;
          end
          CMD: if (cmd) state <= WR_WAIT;
          else begin
            {bus.wb_cyc, bus.wb_stb} <= 2'b11;
            state <= RD_EXE;
          end
          WR_WAIT: if (bus.spi_rdy) begin
            bus.wb_wdat <= bus.spi_rx;
            {bus.wb_cyc, bus.wb_stb, bus.wb_we} <= '1;
            state <= WR_EXE;
          end else if (bus.spi_cs_n) state <= IDLE;
          WR_EXE: if (ok) begin
            {bus.wb_cyc, bus.wb_stb, bus.wb_we} <= '0;
            bus.wb_adr <= bus.wb_adr + INC;
            // a byte arriving with the ack skips the buffer and becomes the next access
            if (buf_full || bus.spi_rdy) begin
              bus.wb_wdat <= buf_full ? buf_q : bus.spi_rx;
              buf_full    <= buf_full && bus.spi_rdy;
              buf_q       <= bus.spi_rx;
            end else state <= bus.spi_cs_n ? IDLE : WR_WAIT;
          end else begin
            if (!bus.wb_stb) {bus.wb_cyc, bus.wb_stb, bus.wb_we} <= '1;
            if (bus.spi_rdy) begin
              bus.err[ERR_OVR] <= buf_full;
              buf_full         <= 1'b1;
              if (!buf_full) buf_q <= bus.spi_rx;
            end
          end
          RD_EXE: if (ok) begin
            {bus.wb_cyc, bus.wb_stb} <= '0;
            bus.spi_tx <= bus.wb_rdat;
            bus.wb_adr <= bus.wb_adr + INC;
            bus.spi_ld <= 1'b1;
            state      <= RD_LOAD;
          end
          RD_LOAD: state <= RD_WAIT;
          RD_WAIT: if (bus.spi_rdy) begin
            {bus.wb_cyc, bus.wb_stb} <= 2'b11;
            state <= RD_EXE;
          end else if (bus.spi_cs_n) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
